// File: rtl/ncr_slave_bridge.sv
// Zorro III SCSI-window slave cycle to NCR 53C710 68030-style slave access.
// Drives NCR strobes and data-buffer enables, synchronizes SLACK, bounds access time.
module ncr_slave_bridge #(
    parameter int SETUP_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       IORST_n,
    input  logic       scsi_cycle,
    input  logic       fcs_n,
    input  logic [3:0] ds_n,
    input  logic       read,
    input  logic       slack_n,
    output logic       ncr_sreg_n,
    output logic       ncr_as_n,
    output logic       d2z_n,
    output logic       z2d_n,
    output logic       dboe_n,
    output logic       scsi_dtack,
    output logic       timeout
);

    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;

    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] REC_LAST   = RW'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACCESS, ACK, RECOVER
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0] setup_cnt_q, setup_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [RW-1:0] rec_cnt_q, rec_cnt_d;
    logic [1:0]    slack_q;
    logic          slack_s;
    logic          to_hit;

    logic dir_q, dir_d;
    logic sreg_q, sreg_d;
    logic as_q, as_d;
    logic d2z_q, d2z_d;
    logic z2d_q, z2d_d;
    logic dboe_q, dboe_d;
    logic dtack_q, dtack_d;
    logic to_q, to_d;

    assign slack_s = slack_q[1];

    always_ff @(posedge CLK or negedge IORST_n) begin
        if (!IORST_n) begin
            state_q     <= IDLE;
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
            rec_cnt_q   <= '0;
            slack_q     <= 2'b11;
            dir_q       <= 1'b0;
            sreg_q      <= 1'b1;
            as_q        <= 1'b1;
            d2z_q       <= 1'b1;
            z2d_q       <= 1'b1;
            dboe_q      <= 1'b1;
            dtack_q     <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rec_cnt_q   <= rec_cnt_d;
            slack_q     <= {slack_q[0], slack_n};
            dir_q       <= dir_d;
            sreg_q      <= sreg_d;
            as_q        <= as_d;
            d2z_q       <= d2z_d;
            z2d_q       <= z2d_d;
            dboe_q      <= dboe_d;
            dtack_q     <= dtack_d;
            to_q        <= to_d;
        end
    end

    // FCS_n release outranks SLACK and timeout in every active state
    always_comb begin
        state_d = state_q;
        to_hit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scsi_cycle && !fcs_n && (read || ds_n != 4'hF))
                    state_d = SETUP;
            end
            SETUP: begin
                if (fcs_n)
                    state_d = RECOVER;
                else if (setup_cnt_q == SETUP_LAST)
                    state_d = ACCESS;
            end
            ACCESS: begin
                if (fcs_n) begin
                    state_d = RECOVER;
                end else if (!slack_s) begin
                    state_d = ACK;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ACK;
                    to_hit  = 1'b1;
                end
            end
            ACK: begin
                if (fcs_n)
                    state_d = RECOVER;
            end
            RECOVER: begin
                if (rec_cnt_q == REC_LAST && slack_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters sit at zero outside their state, so they start cleared on entry
    always_comb begin
        setup_cnt_d = '0;
        to_cnt_d    = '0;
        rec_cnt_d   = '0;
        if (state_q == SETUP)
            setup_cnt_d = (setup_cnt_q == SETUP_LAST) ? setup_cnt_q
                                                      : setup_cnt_q + 1'b1;
        if (state_q == ACCESS)
            to_cnt_d = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + 1'b1;
        if (state_q == RECOVER)
            rec_cnt_d = (rec_cnt_q == REC_LAST) ? rec_cnt_q : rec_cnt_q + 1'b1;
    end

    always_comb begin
        logic active;
        logic strobe;
        active  = state_d inside {SETUP, ACCESS, ACK};
        strobe  = state_d inside {ACCESS, ACK};
        dir_d   = (state_q == IDLE && state_d == SETUP) ? read : dir_q;
        dboe_d  = !active;
        d2z_d   = !(active && dir_d);
        z2d_d   = !(active && !dir_d);
        sreg_d  = !strobe;
        as_d    = !strobe;
        dtack_d = (state_d == ACK);
        to_d    = (state_d == ACK) && (to_hit || to_q);
    end

    assign ncr_sreg_n = sreg_q;
    assign ncr_as_n   = as_q;
    assign d2z_n      = d2z_q;
    assign z2d_n      = z2d_q;
    assign dboe_n     = dboe_q;
    assign scsi_dtack = dtack_q;
    assign timeout    = to_q;

endmodule

// File: tb/tb_ncr_slave_bridge.sv
// Bench for ncr_slave_bridge: directed cycles, expected output transitions
// queued with their edge number and checked by an output-change monitor.
module tb_ncr_slave_bridge;

    logic       CLK;
    logic       IORST_n;
    logic       scsi_cycle;
    logic       fcs_n;
    logic [3:0] ds_n;
    logic       read;
    logic       slack_n;
    logic       ncr_sreg_n;
    logic       ncr_as_n;
    logic       d2z_n;
    logic       z2d_n;
    logic       dboe_n;
    logic       scsi_dtack;
    logic       timeout;

    ncr_slave_bridge #(
        .SETUP_CYCLES   (1),
        .TIMEOUT_CYCLES (64),
        .RECOVERY_CYCLES(2)
    ) dut (
        .CLK       (CLK),
        .IORST_n   (IORST_n),
        .scsi_cycle(scsi_cycle),
        .fcs_n     (fcs_n),
        .ds_n      (ds_n),
        .read      (read),
        .slack_n   (slack_n),
        .ncr_sreg_n(ncr_sreg_n),
        .ncr_as_n  (ncr_as_n),
        .d2z_n     (d2z_n),
        .z2d_n     (z2d_n),
        .dboe_n    (dboe_n),
        .scsi_dtack(scsi_dtack),
        .timeout   (timeout)
    );

    // {sreg, as, d2z, z2d, dboe, dtack, timeout}
    localparam logic [6:0] V_IDLE  = 7'b1111100;
    localparam logic [6:0] V_RBUF  = 7'b1101000;
    localparam logic [6:0] V_RSTB  = 7'b0001000;
    localparam logic [6:0] V_RACK  = 7'b0001010;
    localparam logic [6:0] V_RTO   = 7'b0001011;
    localparam logic [6:0] V_WBUF  = 7'b1110000;
    localparam logic [6:0] V_WSTB  = 7'b0010000;
    localparam logic [6:0] V_WACK  = 7'b0010010;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         total;
    int         bad;
    int         cyc;
    logic       mon_en;
    logic [6:0] prev;
    int         p;

    function automatic logic [6:0] outs();
        return {ncr_sreg_n, ncr_as_n, d2z_n, z2d_n, dboe_n, scsi_dtack, timeout};
    endfunction

    function automatic void expect_at(int c, logic [6:0] v, string n);
        exp_t e;
        e.cyc  = c;
        e.vec  = v;
        e.name = n;
        sb.push_back(e);
    endfunction

    task automatic check(string n, logic [6:0] got, logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", n, got, want);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        logic [6:0] v;
        exp_t e;
        if (mon_en) begin
            v = outs();
            if (v !== prev) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got %b at edge %0d want no change",
                             v, cyc);
                end else begin
                    e = sb.pop_front();
                    if (v !== e.vec || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL %s: got %b at edge %0d want %b at edge %0d",
                                 e.name, v, cyc, e.vec, e.cyc);
                    end
                end
                prev = v;
            end
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        mon_en     = 1'b0;
        prev       = V_IDLE;
        IORST_n    = 1'b1;
        scsi_cycle = 1'b0;
        fcs_n      = 1'b1;
        ds_n       = 4'hF;
        read       = 1'b0;
        slack_n    = 1'b1;
        #1 IORST_n = 1'b0;
        #2 check("reset_state", outs(), V_IDLE);
        step(2);
        IORST_n = 1'b1;
        step(2);
        check("post_reset", outs(), V_IDLE);
        mon_en = 1'b1;

        // read, SLACK 4 cycles after strobe
        p = cyc;
        scsi_cycle = 1'b1; read = 1'b1; fcs_n = 1'b0;
        expect_at(p + 1, V_RBUF, "rd_buf");
        expect_at(p + 2, V_RSTB, "rd_strobe");
        step(6);
        slack_n = 1'b0;
        expect_at(p + 9, V_RACK, "rd_dtack");
        step(5);
        fcs_n = 1'b1; scsi_cycle = 1'b0; slack_n = 1'b1;
        expect_at(p + 12, V_IDLE, "rd_release");
        step(6);

        // write, DS_n late
        p = cyc;
        scsi_cycle = 1'b1; read = 1'b0; fcs_n = 1'b0; ds_n = 4'hF;
        step(5);
        ds_n = 4'h0;
        expect_at(p + 6, V_WBUF, "wr_buf");
        expect_at(p + 7, V_WSTB, "wr_strobe");
        step(3);
        slack_n = 1'b0;
        expect_at(p + 11, V_WACK, "wr_dtack");
        step(4);
        fcs_n = 1'b1; scsi_cycle = 1'b0; slack_n = 1'b1; ds_n = 4'hF;
        expect_at(p + 13, V_IDLE, "wr_release");
        step(6);

        // timeout: no SLACK
        p = cyc;
        scsi_cycle = 1'b1; read = 1'b1; fcs_n = 1'b0;
        expect_at(p + 1, V_RBUF, "to_buf");
        expect_at(p + 2, V_RSTB, "to_strobe");
        expect_at(p + 66, V_RTO, "to_dtack");
        step(70);
        fcs_n = 1'b1; scsi_cycle = 1'b0;
        expect_at(p + 71, V_IDLE, "to_release");
        step(6);

        // abort as sync SLACK lands, then recovery gated by SLACK
        p = cyc;
        scsi_cycle = 1'b1; read = 1'b1; fcs_n = 1'b0;
        expect_at(p + 1, V_RBUF, "ab_buf");
        expect_at(p + 2, V_RSTB, "ab_strobe");
        step(1);
        slack_n = 1'b0;
        step(2);
        fcs_n = 1'b1; scsi_cycle = 1'b0;
        expect_at(p + 4, V_IDLE, "ab_release");
        step(2);
        fcs_n = 1'b0; scsi_cycle = 1'b1; read = 1'b1;
        step(3);
        slack_n = 1'b1;
        expect_at(p + 12, V_RBUF, "rec_buf");
        expect_at(p + 13, V_RSTB, "rec_strobe");
        step(7);
        slack_n = 1'b0;
        expect_at(p + 18, V_RACK, "rec_dtack");
        step(5);
        fcs_n = 1'b1; scsi_cycle = 1'b0; slack_n = 1'b1;
        expect_at(p + 21, V_IDLE, "rec_release");
        step(6);

        // reset mid-ACCESS
        p = cyc;
        scsi_cycle = 1'b1; read = 1'b1; fcs_n = 1'b0;
        expect_at(p + 1, V_RBUF, "rst_buf");
        expect_at(p + 2, V_RSTB, "rst_strobe");
        step(3);
        expect_at(p + 3, V_IDLE, "rst_async");
        #1 IORST_n = 1'b0;
        #1 check("rst_immediate", outs(), V_IDLE);
        scsi_cycle = 1'b0; fcs_n = 1'b1;
        #1 IORST_n = 1'b1;
        step(4);
        check("rst_idle_after", outs(), V_IDLE);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_changes: got %0d pending want 0", sb.size());
            while (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("FAIL %s: got no change want %b at edge %0d",
                         e.name, e.vec, e.cyc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
